// File: rtl/demux_defs.sv
// Shared definitions for the serial-to-lane demultiplexer: default lane count,
// select width and the two-state assembly FSM encoding.
package demux_defs;

    localparam int LANES_DEFAULT = 7;
    localparam int SEL_W         = 3;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

endpackage

// File: rtl/lane_decoder.sv
// Turns a lane select plus enable into a one-hot write strobe across WIDTH lanes.
// Selects at or beyond WIDTH produce no strobe at all.
module lane_decoder
    import demux_defs::*;
#(
    parameter int WIDTH = LANES_DEFAULT
) (
    input  logic [SEL_W-1:0] sel_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] strobe_o
);

    always_comb begin
        // NOTE: default first so every path assigns strobe_o and no latch is inferred.
        strobe_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (en_i && (sel_i == SEL_W'(i))) begin
                strobe_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_demux7.sv
// Steers a one-bit serial stream onto WIDTH lanes, by internal pointer or by
// explicit lane select, and publishes each completed word over valid/ready.
module serial_demux7
    import demux_defs::*;
#(
    parameter int WIDTH = LANES_DEFAULT
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             SerialIn,
    input  logic             InValid,
    output logic             InReady,
    input  logic             Addressed,
    input  logic [SEL_W-1:0] MuxSelect,
    output logic [WIDTH-1:0] Out,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Filled
);

    state_e             state_q;
    logic [WIDTH-1:0]   asm_q,  asm_d;
    logic [WIDTH-1:0]   mask_q, mask_d;
    logic [SEL_W-1:0]   ptr_q,  ptr_d;
    logic [WIDTH-1:0]   out_q;
    logic               out_valid_q;

    logic               accept;
    logic               drain;
    logic               complete;
    logic [SEL_W-1:0]   lane_sel;
    logic [WIDTH-1:0]   strobe;

    assign accept   = InValid && (state_q == COLLECT);
    assign drain    = out_valid_q && OutReady;
    assign lane_sel = Addressed ? MuxSelect : ptr_q;

    lane_decoder #(
        .WIDTH (WIDTH)
    ) u_lane_decoder (
        .sel_i    (lane_sel),
        .en_i     (accept),
        .strobe_o (strobe)
    );

    // An out-of-range addressed select yields a zero strobe, so the bit vanishes.
    always_comb begin
        asm_d  = (asm_q & ~strobe) | (strobe & {WIDTH{SerialIn}});
        mask_d = mask_q | strobe;
        ptr_d  = ptr_q;
        if (accept && !Addressed) begin
            ptr_d = (ptr_q == SEL_W'(WIDTH - 1)) ? '0 : ptr_q + 1'b1;
        end
    end

    assign complete = accept && (&mask_d);

    always_ff @(posedge Clock) begin
        // NOTE: reset is sampled on the clock edge, so it lives inside this block
        // and overrides every other input, including a word held for the consumer.
        if (!Resetn) begin
            state_q     <= COLLECT;
            asm_q       <= '0;
            mask_q      <= '0;
            ptr_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                COLLECT: begin
                    if (drain) begin
                        out_valid_q <= 1'b0;
                    end
                    if (complete) begin
                        if (!out_valid_q || drain) begin
                            out_q       <= asm_d;
                            out_valid_q <= 1'b1;
                            asm_q       <= '0;
                            mask_q      <= '0;
                            ptr_q       <= '0;
                        end else begin
                            // Consumer still owns the previous word: park the new one.
                            state_q <= HOLD;
                            asm_q   <= asm_d;
                            mask_q  <= mask_d;
                            ptr_q   <= ptr_d;
                        end
                    end else if (accept) begin
                        asm_q  <= asm_d;
                        mask_q <= mask_d;
                        ptr_q  <= ptr_d;
                    end
                end
                HOLD: begin
                    if (drain) begin
                        out_q       <= asm_q;
                        out_valid_q <= 1'b1;
                        asm_q       <= '0;
                        mask_q      <= '0;
                        ptr_q       <= '0;
                        state_q     <= COLLECT;
                    end
                end
                default: begin
                    state_q <= COLLECT;
                end
            endcase
        end
    end

    assign InReady  = (state_q == COLLECT);
    assign Out      = out_q;
    assign OutValid = out_valid_q;
    assign Filled   = mask_q;

endmodule

// File: tb/tb_serial_demux7.sv
// Directed bench for serial_demux7: hand-computed words for sequential, addressed,
// back-pressure, reset and back-to-back scenarios.
module tb_serial_demux7;

    logic       Clock;
    logic       Resetn;
    logic       SerialIn;
    logic       InValid;
    logic       InReady;
    logic       Addressed;
    logic [2:0] MuxSelect;
    logic [6:0] Out;
    logic       OutValid;
    logic       OutReady;
    logic [6:0] Filled;

    int total = 0;
    int bad   = 0;

    serial_demux7 #(
        .WIDTH (7)
    ) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .SerialIn  (SerialIn),
        .InValid   (InValid),
        .InReady   (InReady),
        .Addressed (Addressed),
        .MuxSelect (MuxSelect),
        .Out       (Out),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .Filled    (Filled)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge with the given inputs presented; outputs settle #1 later.
    task automatic send(input logic addr, input logic [2:0] sel, input logic b);
        Addressed = addr;
        MuxSelect = sel;
        SerialIn  = b;
        InValid   = 1'b1;
        @(posedge Clock);
        #1;
        InValid   = 1'b0;
    endtask

    task automatic idle_edge();
        InValid = 1'b0;
        @(posedge Clock);
        #1;
    endtask

    task automatic send_seq_word(input logic [6:0] w);
        for (int i = 0; i < 7; i++) begin
            send(1'b0, 3'd0, w[i]);
        end
    endtask

    logic [6:0]  lanes_hi_first;
    logic [20:0] stream;
    logic [6:0]  exp_words [3];
    int          words_seen;
    int          ready_low;

    initial begin
        Resetn    = 1'b0;
        SerialIn  = 1'b0;
        InValid   = 1'b0;
        Addressed = 1'b0;
        MuxSelect = 3'd0;
        OutReady  = 1'b0;

        // Reset
        @(posedge Clock); #1;
        @(posedge Clock); #1;
        check("rst_out",     {1'b0, Out},    8'h00);
        check("rst_ovalid",  {7'b0, OutValid}, 8'h00);
        check("rst_filled",  {1'b0, Filled}, 8'h00);
        check("rst_inready", {7'b0, InReady},  8'h01);
        Resetn = 1'b1;

        // Sequential word 1,0,1,1,0,0,1 -> 0x4D
        OutReady = 1'b1;
        send(1'b0, 3'd0, 1'b1);
        send(1'b0, 3'd0, 1'b0);
        send(1'b0, 3'd0, 1'b1);
        send(1'b0, 3'd0, 1'b1);
        send(1'b0, 3'd0, 1'b0);
        send(1'b0, 3'd0, 1'b0);
        check("seq_filled6", {1'b0, Filled}, 8'h3F);
        check("seq_ovalid6", {7'b0, OutValid}, 8'h00);
        send(1'b0, 3'd0, 1'b1);
        check("seq_ovalid",  {7'b0, OutValid}, 8'h01);
        check("seq_out",     {1'b0, Out},    8'h4D);
        check("seq_filled",  {1'b0, Filled}, 8'h00);
        check("seq_inready", {7'b0, InReady},  8'h01);
        idle_edge();
        check("seq_drained", {7'b0, OutValid}, 8'h00);
        check("seq_out_keep", {1'b0, Out},   8'h4D);

        // Addressed lanes 6..0 all ones, with an out-of-range select mid-stream
        send(1'b1, 3'd6, 1'b1);
        send(1'b1, 3'd5, 1'b1);
        send(1'b1, 3'd4, 1'b1);
        check("adr_filled3", {1'b0, Filled}, 8'h70);
        send(1'b1, 3'd7, 1'b0);
        check("adr_sel7_filled", {1'b0, Filled}, 8'h70);
        check("adr_sel7_ovalid", {7'b0, OutValid}, 8'h00);
        send(1'b1, 3'd3, 1'b1);
        send(1'b1, 3'd2, 1'b1);
        send(1'b1, 3'd1, 1'b1);
        send(1'b1, 3'd0, 1'b1);
        check("adr_ovalid", {7'b0, OutValid}, 8'h01);
        check("adr_out",    {1'b0, Out},    8'h7F);
        idle_edge();

        // Back-pressure: second word parks in HOLD until OutReady
        OutReady = 1'b0;
        send_seq_word(7'h4D);
        check("bp_first_out",    {1'b0, Out},    8'h4D);
        check("bp_first_ovalid", {7'b0, OutValid}, 8'h01);
        send_seq_word(7'h00);
        check("bp_hold_inready", {7'b0, InReady},  8'h00);
        check("bp_hold_out",     {1'b0, Out},    8'h4D);
        check("bp_hold_filled",  {1'b0, Filled}, 8'h7F);
        send(1'b0, 3'd0, 1'b1);
        check("bp_ignored_filled", {1'b0, Filled}, 8'h7F);
        check("bp_ignored_out",    {1'b0, Out},    8'h4D);
        OutReady = 1'b1;
        idle_edge();
        OutReady = 1'b0;
        check("bp_rel_out",     {1'b0, Out},    8'h00);
        check("bp_rel_ovalid",  {7'b0, OutValid}, 8'h01);
        check("bp_rel_inready", {7'b0, InReady},  8'h01);
        check("bp_rel_filled",  {1'b0, Filled}, 8'h00);
        OutReady = 1'b1;
        idle_edge();
        check("bp_drained", {7'b0, OutValid}, 8'h00);

        // Duplicate write of lane 2 (1 then 0), rest ones -> 0x7B
        send(1'b1, 3'd2, 1'b1);
        send(1'b1, 3'd2, 1'b0);
        check("dup_filled", {1'b0, Filled}, 8'h04);
        send(1'b1, 3'd0, 1'b1);
        send(1'b1, 3'd1, 1'b1);
        send(1'b1, 3'd3, 1'b1);
        send(1'b1, 3'd4, 1'b1);
        send(1'b1, 3'd5, 1'b1);
        send(1'b1, 3'd6, 1'b1);
        check("dup_out",    {1'b0, Out},    8'h7B);
        check("dup_ovalid", {7'b0, OutValid}, 8'h01);
        idle_edge();

        // Mid-word reset, with a bit offered on the reset edge
        send_seq_word(7'h00);  // one full zero word passes straight through
        idle_edge();
        for (int i = 0; i < 4; i++) send(1'b0, 3'd0, 1'b1);
        check("mrst_pre_filled", {1'b0, Filled}, 8'h0F);
        Resetn = 1'b0;
        send(1'b0, 3'd0, 1'b1);
        Resetn = 1'b1;
        check("mrst_filled", {1'b0, Filled}, 8'h00);
        check("mrst_out",    {1'b0, Out},    8'h00);
        check("mrst_ovalid", {7'b0, OutValid}, 8'h00);
        OutReady = 1'b0;
        send(1'b0, 3'd0, 1'b0);
        check("mrst_ptr0", {1'b0, Filled}, 8'h01);
        lanes_hi_first = 7'h32;
        for (int i = 1; i < 7; i++) send(1'b0, 3'd0, lanes_hi_first[i]);
        check("mrst_out_word", {1'b0, Out},    8'h32);
        check("mrst_ovalid2",  {7'b0, OutValid}, 8'h01);

        // Completion and drain in the same edge: no HOLD
        for (int i = 0; i < 6; i++) send(1'b0, 3'd0, i[0] ? 1'b0 : 1'b1);
        OutReady = 1'b1;
        send(1'b0, 3'd0, 1'b1);
        check("same_out",     {1'b0, Out},    8'h55);
        check("same_ovalid",  {7'b0, OutValid}, 8'h01);
        check("same_inready", {7'b0, InReady},  8'h01);

        // Three back-to-back words with OutReady held high
        exp_words[0] = 7'h55;
        exp_words[1] = 7'h2A;
        exp_words[2] = 7'h4D;
        stream     = {exp_words[2], exp_words[1], exp_words[0]};
        words_seen = 0;
        ready_low  = 0;
        for (int i = 0; i < 21; i++) begin
            if (!InReady) ready_low++;
            send(1'b0, 3'd0, stream[i]);
            if (OutValid) begin
                if (words_seen < 3) begin
                    check($sformatf("b2b_word%0d", words_seen), {1'b0, Out},
                          {1'b0, exp_words[words_seen]});
                end
                words_seen++;
            end
        end
        check("b2b_count",     8'(words_seen), 8'd3);
        check("b2b_ready_low", 8'(ready_low),  8'd0);
        idle_edge();
        check("b2b_drained", {7'b0, OutValid}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
